// File: rtl/alu_pkg.sv
// Shared constants for the MCU datapath ALU: widths and operation codes.
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int ALU_OP_W = 7;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 7'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 7'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 7'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 7'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 7'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 7'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 7'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 7'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 7'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 7'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 7'd10;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 7'd11;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter shared by SLL, SRL and SRA.
// Left shifts are done as right shifts on the bit-reversed word so that a
// single stage chain serves both directions.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] shamt,
  input  logic          dir,     // 0 = left, 1 = right
  input  logic          arith,   // right shifts only: sign-fill from data[W-1]
  output logic [W-1:0]  shifted
);

  logic [W-1:0]       data_rev;
  logic [W-1:0]       out_rev;
  logic [SW:0][W-1:0] stage;
  logic               fill;

  // Sign fill only makes sense for a right shift; left shifts always fill 0.
  assign fill = dir & arith & data[W-1];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rev
      assign data_rev[gi] = data[W-1-gi];
      assign out_rev[gi]  = stage[SW][W-1-gi];
    end

    for (gi = 0; gi < SW; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = shamt[gi] ? {{SH{fill}}, stage[gi][W-1:SH]} : stage[gi];
    end
  endgenerate

  assign stage[0] = dir ? data : data_rev;
  assign shifted  = dir ? stage[SW] : out_rev;

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU: combinational operation select into a single result
// register, one cycle of latency, a new operation every cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] operation,
  output logic [WIDTH-1:0]    result
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] shift_out;
  logic             shift_dir;
  logic             shift_arith;

  // Only SLL shifts left; SRA is the only sign-filling shift.
  assign shift_dir   = (operation != ALU_SLL);
  assign shift_arith = (operation == ALU_SRA);

  alu_shifter #(
    .W  (WIDTH),
    .SW (SW)
  ) u_shifter (
    .data    (a),
    .shamt   (b[SW-1:0]),
    .dir     (shift_dir),
    .arith   (shift_arith),
    .shifted (shift_out)
  );

  // Operation select; reserved codes produce zero.
  always_comb begin
    result_next = '0;
    case (operation)
      ALU_ADD:   result_next = a + b;
      ALU_SUB:   result_next = a - b;
      ALU_AND:   result_next = a & b;
      ALU_OR:    result_next = a | b;
      ALU_XOR:   result_next = a ^ b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   result_next = shift_out;
      ALU_SLT:   result_next = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result_next = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASSB: result_next = b;
      ALU_EQ:    result_next = {{(WIDTH-1){1'b0}}, (a == b)};
      default:   result_next = '0;
    endcase
  end

  // Result register; reset overrides whatever operation is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes the expected result when it
// presents an operation, the monitor pops and compares one edge later.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [6:0]  operation;
  logic [31:0] result;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  int tests_run;
  int tests_failed;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .operation (operation),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, reports one line per transaction.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s got=%08h", tag, got);
    end
  endtask

  // Reference model written independently of the RTL structure.
  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [6:0] mop);
    logic [31:0] r;
    r = 32'h0;
    case (mop)
      7'd0:  r = ma + mb;
      7'd1:  r = ma - mb;
      7'd2:  r = ma & mb;
      7'd3:  r = ma | mb;
      7'd4:  r = ma ^ mb;
      7'd5:  r = ma << mb[4:0];
      7'd6:  r = ma >> mb[4:0];
      7'd7: begin
        r = ma;
        for (int i = 0; i < int'(mb[4:0]); i++) r = {r[31], r[31:1]};
      end
      7'd8:  r = (ma[31] != mb[31]) ? {31'b0, ma[31]} : {31'b0, ma < mb};
      7'd9:  r = {31'b0, ma < mb};
      7'd10: r = mb;
      7'd11: r = {31'b0, ma == mb};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Present one operation for one cycle and record what must come out.
  task automatic drive(input string tag, input logic r, input logic [31:0] da,
                       input logic [31:0] db, input logic [6:0] dop,
                       input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    rst       = r;
    a         = da;
    b         = db;
    operation = dop;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per edge while the scoreboard holds entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq(e.tag, result, e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [6:0]  rop;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; a = '0; b = '0; operation = '0;

    // Reset wins over a live ADD, then the ADD shows up after release.
    drive("rst0",      1'b1, 32'd5, 32'd6, 7'd0, 32'h0);
    drive("rst1",      1'b1, 32'd5, 32'd6, 7'd0, 32'h0);
    drive("rst_rel",   1'b0, 32'd5, 32'd6, 7'd0, 32'd11);

    // Arithmetic and wraparound, back to back.
    drive("add",       1'b0, 32'd1, 32'd2, 7'd0, 32'd3);
    drive("sub",       1'b0, 32'd7, 32'd2, 7'd1, 32'd5);
    drive("sub_wrap",  1'b0, 32'd0, 32'd1, 7'd1, 32'hFFFF_FFFF);
    drive("add_wrap",  1'b0, 32'hFFFF_FFFF, 32'd1, 7'd0, 32'h0);

    // Logic.
    drive("and",       1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'd2, 32'hF000_F000);
    drive("or",        1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'd3, 32'hFFF0_FFF0);
    drive("xor",       1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'd4, 32'h0FF0_0FF0);

    // Shifts, including upper shift bits ignored (shamt 0).
    drive("sll",       1'b0, 32'h8000_0001, 32'd4, 7'd5, 32'h0000_0010);
    drive("srl",       1'b0, 32'h8000_0001, 32'd4, 7'd6, 32'h0800_0000);
    drive("sra",       1'b0, 32'h8000_0001, 32'd4, 7'd7, 32'hF800_0000);
    drive("sll_sh0",   1'b0, 32'h8000_0001, 32'h20, 7'd5, 32'h8000_0001);
    drive("srl_sh0",   1'b0, 32'h8000_0001, 32'h20, 7'd6, 32'h8000_0001);
    drive("sra_sh0",   1'b0, 32'h8000_0001, 32'h20, 7'd7, 32'h8000_0001);
    drive("sra_31",    1'b0, 32'h8000_0000, 32'd31, 7'd7, 32'hFFFF_FFFF);
    drive("srl_31",    1'b0, 32'h8000_0000, 32'd31, 7'd6, 32'h0000_0001);
    drive("sll_31",    1'b0, 32'h0000_0001, 32'd31, 7'd5, 32'h8000_0000);

    // Compares and pass-through.
    drive("slt",       1'b0, 32'hFFFF_FFFF, 32'd1, 7'd8, 32'd1);
    drive("sltu",      1'b0, 32'hFFFF_FFFF, 32'd1, 7'd9, 32'd0);
    drive("slt_pos",   1'b0, 32'd1, 32'hFFFF_FFFF, 7'd8, 32'd0);
    drive("eq_true",   1'b0, 32'd1234, 32'd1234, 7'd11, 32'd1);
    drive("eq_false",  1'b0, 32'd1, 32'd2, 7'd11, 32'd0);
    drive("passb",     1'b0, 32'h1111_1111, 32'hCAFE_F00D, 7'd10, 32'hCAFE_F00D);

    // Reserved codes.
    drive("rsv100",    1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 7'd100, 32'h0);
    drive("rsv12",     1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 7'd12, 32'h0);
    drive("rsv127",    1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 7'd127, 32'h0);

    // Reset mid-stream discards the in-flight result.
    drive("pre_rst",   1'b0, 32'd3, 32'd4, 7'd0, 32'd7);
    drive("mid_rst",   1'b1, 32'd3, 32'd4, 7'd0, 32'h0);
    drive("post_rst",  1'b0, 32'd9, 32'd4, 7'd1, 32'd5);

    // Random back-to-back stream against the model.
    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rb  = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
      if (i % 7 == 0) rb = ra;
      rop = (i % 10 == 9) ? 7'($urandom_range(12, 127)) : 7'($urandom_range(0, 11));
      drive($sformatf("rnd%0d_op%0d", i, rop), 1'b0, ra, rb, rop, model(ra, rb, rop));
    end

    // Let the last result emerge, then confirm nothing was left unmatched.
    repeat (3) @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
